i2c_reg_capture: RTL and testbench

- Sits directly downstream of the I2C micro-sequencer.
- Consumes its register-write strobe (5-bit register address, 8-bit read data) and holds a 32-entry shadow bank of values read back from the audio codec over I2C.
- Detects value changes, queues them as (addr, data) events in a small FIFO with a valid/ready handshake, and offers a registered random-access read port for status logic and the debug path.

---
 rtl/i2c_pkg.sv | 42 ++++
 rtl/sync_fifo_fwft.sv | 75 +++++++
 rtl/i2c_reg_capture.sv | 114 +++++++++++
 tb/tb_i2c_reg_capture.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C codec-control path: register geometry, the
// change-event record, and the sequencer opcode/state encodings.
package i2c_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 8;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } evt_t;

  localparam int EVT_W = $bits(evt_t);

  typedef enum logic [1:0] {
    SEQ_OP_NOP   = 2'd0,
    SEQ_OP_WRITE = 2'd1,
    SEQ_OP_READ  = 2'd2,
    SEQ_OP_WAIT  = 2'd3
  } seq_op_e;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_START = 3'd1,
    SEQ_ADDR  = 3'd2,
    SEQ_DATA  = 3'd3,
    SEQ_ACK   = 3'd4,
    SEQ_STOP  = 3'd5
  } seq_state_e;

  function automatic evt_t make_evt(input reg_addr_t addr, input reg_data_t data);
    evt_t e;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. The head output holds the last
// popped word while empty, so downstream sees no stale storage contents.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A push while full is accepted only when a pop frees a slot in the same cycle.
  assign wr_en = push_i && (!full_o || pop_i);
  assign rd_en = pop_i && !empty_o;

  assign dout_o = empty_o ? last_q : mem[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_d   = mem[rd_ptr_q];
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  // NOTE: storage is not reset; dout_o is masked by empty_o, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/i2c_reg_capture.sv
// Shadow bank of codec registers read back over I2C; value changes are queued
// as (addr, data) events and a registered random-read port serves status logic.
module i2c_reg_capture
  import i2c_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] reg_addr,
  input  logic [REG_DATA_W-1:0] reg_data,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic [REG_DATA_W-1:0] rd_data,
  output logic                  rd_valid,
  output logic [NUM_REGS-1:0]   valid_map,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [REG_ADDR_W-1:0] evt_addr,
  output logic [REG_DATA_W-1:0] evt_data,
  output logic                  evt_overflow,
  input  logic                  clear_overflow,
  output logic [CNT_W-1:0]      change_count
);

  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

  reg_data_t             bank_q [NUM_REGS];
  logic [NUM_REGS-1:0]   valid_map_q;
  reg_data_t             rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  changed, evt_gen, pop, drop;
  logic                  fifo_full, fifo_empty;
  logic [EVT_W-1:0]      fifo_dout;
  logic [FIFO_CNT_W-1:0] fifo_count;
  evt_t                  head;
  logic                  unused_fifo_count;

  // Compare against the pre-write contents; an unwritten entry always counts as a change.
  assign changed = !valid_map_q[reg_addr] || (bank_q[reg_addr] != reg_data);
  assign evt_gen = reg_write && changed;
  assign pop     = !fifo_empty && evt_ready;
  assign drop    = evt_gen && fifo_full && !pop;

  sync_fifo_fwft #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (evt_gen),
    .din_i   (make_evt(reg_addr, reg_data)),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign unused_fifo_count = ^fifo_count;

  always_comb begin
    overflow_d = overflow_q;
    if (drop)                overflow_d = 1'b1;
    else if (clear_overflow) overflow_d = 1'b0;

    count_d = count_q;
    if (evt_gen && (count_q != '1)) count_d = count_q + 1'b1;

    // Write-first bypass so a same-cycle read returns the data being captured.
    if (reg_write && (reg_addr == rd_addr)) begin
      rd_data_d  = reg_data;
      rd_valid_d = 1'b1;
    end else begin
      rd_data_d  = bank_q[rd_addr];
      rd_valid_d = valid_map_q[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= '0;
      valid_map_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      if (reg_write) begin
        bank_q[reg_addr]      <= reg_data;
        valid_map_q[reg_addr] <= 1'b1;
      end
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
    end
  end

  assign head         = evt_t'(fifo_dout);
  assign evt_valid    = !fifo_empty;
  assign evt_addr     = head.addr;
  assign evt_data     = head.data;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign valid_map    = valid_map_q;
  assign evt_overflow = overflow_q;
  assign change_count = count_q;

endmodule

// File: tb/tb_i2c_reg_capture.sv
// Directed bench for i2c_reg_capture: capture, change detect, FIFO overflow and
// simultaneous push/pop, read bypass, and reset with events pending.
module tb_i2c_reg_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  reg_addr;
  logic [7:0]  reg_data;
  logic        reg_write;
  logic [4:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [31:0] valid_map;
  logic        evt_valid;
  logic        evt_ready;
  logic [4:0]  evt_addr;
  logic [7:0]  evt_data;
  logic        evt_overflow;
  logic        clear_overflow;
  logic [15:0] change_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  i2c_reg_capture #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .reg_addr       (reg_addr),
    .reg_data       (reg_data),
    .reg_write      (reg_write),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .valid_map      (valid_map),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_addr       (evt_addr),
    .evt_data       (evt_data),
    .evt_overflow   (evt_overflow),
    .clear_overflow (clear_overflow),
    .change_count   (change_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    reg_write = 1'b1;
    reg_addr  = a;
    reg_data  = d;
    tick();
    reg_write = 1'b0;
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; reg_addr = '0; reg_data = '0; reg_write = 1'b0;
    rd_addr = '0; evt_ready = 1'b0; clear_overflow = 1'b0;
    tick(); tick();
    check("rst_evt_valid", 32'(evt_valid), 32'd0);
    check("rst_evt_addr", 32'(evt_addr), 32'd0);
    check("rst_evt_data", 32'(evt_data), 32'd0);
    check("rst_overflow", 32'(evt_overflow), 32'd0);
    check("rst_count", 32'(change_count), 32'd0);
    check("rst_valid_map", valid_map, 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    rst = 1'b0;
    tick();

    // First capture
    wr(5'h05, 8'hA3);
    check("t1_evt_valid", 32'(evt_valid), 32'd1);
    check("t1_evt_addr", 32'(evt_addr), 32'h05);
    check("t1_evt_data", 32'(evt_data), 32'hA3);
    check("t1_valid_map", valid_map, 32'h0000_0020);
    check("t1_count", 32'(change_count), 32'd1);
    pop_one();
    check("t1_pop_empty", 32'(evt_valid), 32'd0);
    check("t1_hold_addr", 32'(evt_addr), 32'h05);
    check("t1_hold_data", 32'(evt_data), 32'hA3);

    // Identical rewrite, then a real change
    wr(5'h05, 8'hA3);
    check("t2_repeat_valid", 32'(evt_valid), 32'd0);
    check("t2_repeat_count", 32'(change_count), 32'd1);
    wr(5'h05, 8'h7F);
    check("t2_chg_valid", 32'(evt_valid), 32'd1);
    check("t2_chg_data", 32'(evt_data), 32'h7F);
    check("t2_chg_count", 32'(change_count), 32'd2);
    pop_one();

    // Nine changes into an 8-deep FIFO with no consumer
    for (int i = 0; i < 9; i++) wr(5'(8'h10 + i), 8'(8'h40 + i));
    check("t3_overflow", 32'(evt_overflow), 32'd1);
    check("t3_count", 32'(change_count), 32'd11);
    check("t3_occupancy", 32'(dut.u_fifo.count_o), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_head_addr%0d", i), 32'(evt_addr), 32'h10 + i);
      check($sformatf("t3_head_data%0d", i), 32'(evt_data), 32'h40 + i);
      pop_one();
    end
    check("t3_drained", 32'(evt_valid), 32'd0);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("t3_ovf_cleared", 32'(evt_overflow), 32'd0);

    // Fill, then push+pop while full, then a dropped push racing a clear
    for (int i = 0; i < 8; i++) wr(5'(i), 8'(8'h80 + i));
    check("t4_full_occ", 32'(dut.u_fifo.count_o), 32'd8);
    check("t4_full_count", 32'(change_count), 32'd19);
    evt_ready = 1'b1;
    wr(5'h08, 8'h55);
    evt_ready = 1'b0;
    check("t4_pp_occ", 32'(dut.u_fifo.count_o), 32'd8);
    check("t4_pp_overflow", 32'(evt_overflow), 32'd0);
    check("t4_pp_head_addr", 32'(evt_addr), 32'h01);
    check("t4_pp_head_data", 32'(evt_data), 32'h81);
    check("t4_pp_count", 32'(change_count), 32'd20);
    clear_overflow = 1'b1;
    wr(5'h09, 8'h66);
    clear_overflow = 1'b0;
    check("t4_set_beats_clear", 32'(evt_overflow), 32'd1);
    check("t4_drop_count", 32'(change_count), 32'd21);
    for (int i = 1; i < 8; i++) begin
      check($sformatf("t4_head_data%0d", i), 32'(evt_data), 32'h80 + i);
      pop_one();
    end
    check("t4_last_addr", 32'(evt_addr), 32'h08);
    check("t4_last_data", 32'(evt_data), 32'h55);
    pop_one();
    check("t4_drained", 32'(evt_valid), 32'd0);

    // Read port: write-first bypass, unwritten entry, plain read
    rd_addr = 5'h05;
    wr(5'h05, 8'h11);
    check("t5_bypass_data", 32'(rd_data), 32'h11);
    check("t5_bypass_valid", 32'(rd_valid), 32'd1);
    rd_addr = 5'h1F;
    tick();
    check("t5_unwritten_data", 32'(rd_data), 32'h00);
    check("t5_unwritten_valid", 32'(rd_valid), 32'd0);
    rd_addr = 5'h10;
    tick();
    check("t5_plain_data", 32'(rd_data), 32'h40);
    check("t5_plain_valid", 32'(rd_valid), 32'd1);

    // Back-to-back writes to one address
    rd_addr = 5'h05;
    wr(5'h1E, 8'h01);
    wr(5'h1E, 8'h01);
    wr(5'h1E, 8'h02);
    check("t6_b2b_count", 32'(change_count), 32'd24);
    check("t6_queued", 32'(dut.u_fifo.count_o), 32'd3);
    check("t6_rd_data", 32'(rd_data), 32'h11);

    // Reset mid-write with events queued
    reg_write = 1'b1; reg_addr = 5'h03; reg_data = 8'h99;
    #1 rst = 1'b1;
    #1;
    check("t7_rst_evt_valid", 32'(evt_valid), 32'd0);
    check("t7_rst_evt_addr", 32'(evt_addr), 32'd0);
    check("t7_rst_evt_data", 32'(evt_data), 32'd0);
    check("t7_rst_count", 32'(change_count), 32'd0);
    check("t7_rst_valid_map", valid_map, 32'd0);
    check("t7_rst_rd_data", 32'(rd_data), 32'd0);
    check("t7_rst_rd_valid", 32'(rd_valid), 32'd0);
    check("t7_rst_overflow", 32'(evt_overflow), 32'd0);
    reg_write = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    wr(5'h05, 8'h11);
    check("t7_recap_valid", 32'(evt_valid), 32'd1);
    check("t7_recap_addr", 32'(evt_addr), 32'h05);
    check("t7_recap_data", 32'(evt_data), 32'h11);
    check("t7_recap_count", 32'(change_count), 32'd1);
    check("t7_recap_map", valid_map, 32'h0000_0020);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
